// File: rtl/sba_mem_bridge.sv
// Bridges a 64-bit SBA master onto a 32-bit req/gnt/rvalid memory port.
// Each access becomes up to two 32-bit beats; a range check and a per-beat timeout bound every transaction.
module sba_mem_bridge #(
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sba_req_i,
  input  logic [63:0]          sba_addr_i,
  input  logic                 sba_we_i,
  input  logic [63:0]          sba_wdata_i,
  input  logic [7:0]           sba_be_i,
  output logic                 sba_gnt_o,
  output logic                 sba_rvalid_o,
  output logic [63:0]          sba_rdata_o,
  output logic                 sba_err_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_err_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LO_REQ  = 3'd1,
    LO_WAIT = 3'd2,
    HI_REQ  = 3'd3,
    HI_WAIT = 3'd4,
    RESP    = 3'd5
  } state_e;

  // The counter is checked one cycle early so the limit lands on cycle TimeoutCycles.
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

  state_e                 state_r;
  logic [AddrWidth-1:3]   addr_r;
  logic                   we_r;
  logic [31:0]            wdata_hi_r;
  logic [3:0]             be_hi_r;
  logic [63:0]            rdata_r;
  logic                   err_r;
  logic [15:0]            cnt_r;
  logic                   rvalid_r;
  logic                   mem_req_r;
  logic [AddrWidth-1:0]   mem_addr_r;
  logic                   mem_we_r;
  logic [3:0]             mem_be_r;
  logic [31:0]            mem_wdata_r;
  logic                   out_of_range_s;
  logic                   timeout_s;
  logic                   beat_err_s;

  assign sba_gnt_o      = (state_r == IDLE) & sba_req_i;
  assign out_of_range_s = |(sba_addr_i >> AddrWidth);
  assign timeout_s      = (cnt_r == TimeoutLast);
  assign beat_err_s     = err_r | mem_err_i;

  assign sba_rvalid_o = rvalid_r;
  assign sba_rdata_o  = rdata_r;
  assign sba_err_o    = err_r;
  assign mem_req_o    = mem_req_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_we_o     = mem_we_r;
  assign mem_be_o     = mem_be_r;
  assign mem_wdata_o  = mem_wdata_r;

  // Transaction FSM with registered SBA and memory-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      we_r        <= 1'b0;
      wdata_hi_r  <= 32'd0;
      be_hi_r     <= 4'd0;
      rdata_r     <= 64'd0;
      err_r       <= 1'b0;
      cnt_r       <= 16'd0;
      rvalid_r    <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      rvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sba_req_i) begin
            addr_r     <= sba_addr_i[AddrWidth-1:3];
            we_r       <= sba_we_i;
            wdata_hi_r <= sba_wdata_i[63:32];
            be_hi_r    <= sba_be_i[7:4];
            rdata_r    <= 64'd0;
            err_r      <= 1'b0;
            cnt_r      <= 16'd0;
            mem_we_r   <= sba_we_i;
            if (out_of_range_s) begin
              err_r    <= 1'b1;
              rvalid_r <= 1'b1;
              state_r  <= RESP;
            end else if (|sba_be_i[3:0]) begin
              mem_req_r   <= 1'b1;
              mem_addr_r  <= {sba_addr_i[AddrWidth-1:3], 3'b000};
              mem_be_r    <= sba_be_i[3:0];
              mem_wdata_r <= sba_wdata_i[31:0];
              state_r     <= LO_REQ;
            end else if (|sba_be_i[7:4]) begin
              mem_req_r   <= 1'b1;
              mem_addr_r  <= {sba_addr_i[AddrWidth-1:3], 3'b100};
              mem_be_r    <= sba_be_i[7:4];
              mem_wdata_r <= sba_wdata_i[63:32];
              state_r     <= HI_REQ;
            end else begin
              rvalid_r <= 1'b1;
              state_r  <= RESP;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LO_REQ, HI_REQ: begin
          cnt_r <= cnt_r + 16'd1;
          if (timeout_s) begin
            mem_req_r <= 1'b0;
            err_r     <= 1'b1;
            rvalid_r  <= 1'b1;
            state_r   <= RESP;
          end else if (mem_gnt_i) begin
            mem_req_r <= 1'b0;
            state_r   <= (state_r == LO_REQ) ? LO_WAIT : HI_WAIT;
          end else begin
            state_r <= state_r;
          end
        end
        LO_WAIT, HI_WAIT: begin
          cnt_r <= cnt_r + 16'd1;
          if (mem_rvalid_i) begin
            err_r <= beat_err_s;
            if (!we_r) begin
              if (state_r == LO_WAIT) begin
                rdata_r[31:0] <= mem_rdata_i;
              end else begin
                rdata_r[63:32] <= mem_rdata_i;
              end
            end else begin
              rdata_r <= rdata_r;
            end
            // An errored LO beat suppresses the HI beat.
            if ((state_r == LO_WAIT) && (|be_hi_r) && !beat_err_s) begin
              cnt_r       <= 16'd0;
              mem_req_r   <= 1'b1;
              mem_addr_r  <= {addr_r, 3'b100};
              mem_be_r    <= be_hi_r;
              mem_wdata_r <= wdata_hi_r;
              state_r     <= HI_REQ;
            end else begin
              rvalid_r <= 1'b1;
              state_r  <= RESP;
            end
          end else if (timeout_s) begin
            err_r    <= 1'b1;
            rvalid_r <= 1'b1;
            state_r  <= RESP;
          end else begin
            state_r <= state_r;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sba_mem_bridge.sv
// Directed self-checking bench for sba_mem_bridge: one default instance with a
// memory responder, plus a TimeoutCycles=4 instance whose memory never grants.
module tb_sba_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sba_req = 1'b0;
  logic        to_req = 1'b0;
  logic [63:0] sba_addr = 64'd0;
  logic        sba_we = 1'b0;
  logic [63:0] sba_wdata = 64'd0;
  logic [7:0]  sba_be = 8'd0;

  logic        sba_gnt, sba_rvalid, sba_err;
  logic [63:0] sba_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  logic        to_gnt, to_rvalid, to_err, to_mem_req, to_mem_we;
  logic [63:0] to_rdata;
  logic [15:0] to_mem_addr;
  logic [3:0]  to_mem_be;
  logic [31:0] to_mem_wdata;

  // memory model controls and observation
  logic        gnt_en = 1'b1;
  logic        err_inj = 1'b0;
  logic        block_hi = 1'b0;
  logic        man_rvalid = 1'b0;
  logic        man_err = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  int          beats = 0;
  int          req_cycles = 0;
  int          to_req_cycles = 0;
  logic [15:0] last_addr = 16'd0;
  logic [3:0]  last_be = 4'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        last_we = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sba_mem_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .sba_req_i(sba_req), .sba_addr_i(sba_addr), .sba_we_i(sba_we),
    .sba_wdata_i(sba_wdata), .sba_be_i(sba_be),
    .sba_gnt_o(sba_gnt), .sba_rvalid_o(sba_rvalid), .sba_rdata_o(sba_rdata), .sba_err_o(sba_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  sba_mem_bridge #(.AddrWidth(16), .TimeoutCycles(4)) dut_to (
    .clk_i(clk), .rst_i(rst),
    .sba_req_i(to_req), .sba_addr_i(sba_addr), .sba_we_i(sba_we),
    .sba_wdata_i(sba_wdata), .sba_be_i(sba_be),
    .sba_gnt_o(to_gnt), .sba_rvalid_o(to_rvalid), .sba_rdata_o(to_rdata), .sba_err_o(to_err),
    .mem_req_o(to_mem_req), .mem_gnt_i(1'b0), .mem_addr_o(to_mem_addr), .mem_we_o(to_mem_we),
    .mem_be_o(to_mem_be), .mem_wdata_o(to_mem_wdata),
    .mem_rvalid_i(1'b0), .mem_rdata_i(32'd0), .mem_err_i(1'b0)
  );

  function automatic logic [31:0] lookup(input logic [15:0] a);
    case (a)
      16'h1000: return 32'h11223344;
      16'h1004: return 32'hAABBCCDD;
      default:  return {16'hC0DE, a};
    endcase
  endfunction

  assign mem_gnt    = mem_req & gnt_en;
  assign mem_rvalid = m_rvalid | man_rvalid;
  assign mem_rdata  = man_rvalid ? 32'h5A5A5A5A : m_rdata;
  assign mem_err    = m_err | man_err;

  // Memory responder: rvalid one cycle after each handshake, beat logging.
  always @(posedge clk) begin
    m_rvalid <= mem_req & mem_gnt & !(block_hi & mem_addr[2]);
    m_err    <= mem_req & mem_gnt & err_inj;
    m_rdata  <= lookup(mem_addr);
    if (mem_req) req_cycles <= req_cycles + 1;
    if (to_mem_req) to_req_cycles <= to_req_cycles + 1;
    if (mem_req & mem_gnt) begin
      beats      <= beats + 1;
      last_addr  <= mem_addr;
      last_be    <= mem_be;
      last_wdata <= mem_wdata;
      last_we    <= mem_we;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drive one request; returns after the grant edge with lat=1 (first cycle after grant).
  task automatic start(input bit which, input logic [63:0] a, input logic we,
                       input logic [63:0] wd, input logic [7:0] be, output int lat);
    @(negedge clk);
    sba_addr = a; sba_we = we; sba_wdata = wd; sba_be = be;
    if (which) to_req = 1'b1; else sba_req = 1'b1;
    #1;
    if (!which) check("sba_gnt", {63'd0, sba_gnt}, 64'd1);
    @(negedge clk);
    sba_req = 1'b0; to_req = 1'b0;
    lat = 1;
  endtask

  task automatic wait_resp(input bit which, inout int lat);
    while (!(which ? to_rvalid : sba_rvalid) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", {63'd0, (which ? to_rvalid : sba_rvalid)}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, b0, r0;
    repeat (3) @(negedge clk);
    // reset state
    check("rst_rvalid", {63'd0, sba_rvalid}, 64'd0);
    check("rst_memreq", {63'd0, mem_req}, 64'd0);
    check("rst_rdata", sba_rdata, 64'd0);
    check("rst_err", {63'd0, sba_err}, 64'd0);
    rst = 1'b0;

    // two-beat read
    b0 = beats;
    start(1'b0, 64'h1000, 1'b0, 64'd0, 8'hFF, lat);
    wait_resp(1'b0, lat);
    check("rd2_lat", 64'(lat), 64'd5);
    check("rd2_rdata", sba_rdata, 64'hAABBCCDD11223344);
    check("rd2_err", {63'd0, sba_err}, 64'd0);
    check("rd2_beats", 64'(beats - b0), 64'd2);
    repeat (2) @(negedge clk);
    check("rd2_hold", sba_rdata, 64'hAABBCCDD11223344);
    check("rvalid_pulse", {63'd0, sba_rvalid}, 64'd0);

    // upper-half write
    b0 = beats;
    start(1'b0, 64'h2008, 1'b1, 64'hDEADBEEF_00000000, 8'hF0, lat);
    wait_resp(1'b0, lat);
    check("wr_lat", 64'(lat), 64'd3);
    check("wr_beats", 64'(beats - b0), 64'd1);
    check("wr_addr", 64'(last_addr), 64'h200C);
    check("wr_be", 64'(last_be), 64'hF);
    check("wr_wdata", 64'(last_wdata), 64'hDEADBEEF);
    check("wr_we", {63'd0, last_we}, 64'd1);
    check("wr_err", {63'd0, sba_err}, 64'd0);
    check("wr_rdata", sba_rdata, 64'd0);

    // out of range
    r0 = req_cycles;
    start(1'b0, 64'h0001_0000, 1'b0, 64'd0, 8'hFF, lat);
    wait_resp(1'b0, lat);
    check("oor_lat", 64'(lat), 64'd1);
    check("oor_err", {63'd0, sba_err}, 64'd1);
    check("oor_noreq", 64'(req_cycles - r0), 64'd0);

    // be = 0
    r0 = req_cycles;
    start(1'b0, 64'h1000, 1'b0, 64'd0, 8'h00, lat);
    wait_resp(1'b0, lat);
    check("be0_lat", 64'(lat), 64'd1);
    check("be0_err", {63'd0, sba_err}, 64'd0);
    check("be0_rdata", sba_rdata, 64'd0);
    check("be0_noreq", 64'(req_cycles - r0), 64'd0);

    // timeout on the TimeoutCycles=4 instance
    r0 = to_req_cycles;
    start(1'b1, 64'h0100, 1'b0, 64'd0, 8'hFF, lat);
    wait_resp(1'b1, lat);
    check("to_lat", 64'(lat), 64'd5);
    check("to_err", {63'd0, to_err}, 64'd1);
    check("to_req_cycles", 64'(to_req_cycles - r0), 64'd4);
    repeat (3) @(negedge clk);
    check("to_no_hi", 64'(to_req_cycles - r0), 64'd4);
    check("to_addr", 64'(to_mem_addr), 64'h0100);

    // LO beat error skips the HI beat
    b0 = beats;
    err_inj = 1'b1;
    start(1'b0, 64'h1000, 1'b0, 64'd0, 8'hFF, lat);
    wait_resp(1'b0, lat);
    err_inj = 1'b0;
    check("lerr_lat", 64'(lat), 64'd3);
    check("lerr_err", {63'd0, sba_err}, 64'd1);
    check("lerr_beats", 64'(beats - b0), 64'd1);
    check("lerr_rdata", sba_rdata, 64'h00000000_11223344);

    // gnt stalled 3 cycles while the SBA address wanders
    gnt_en = 1'b0;
    start(1'b0, 64'h1010, 1'b0, 64'd0, 8'h0F, lat);
    for (int i = 0; i < 4; i++) begin
      check("stall_req", {63'd0, mem_req}, 64'd1);
      check("stall_addr", 64'(mem_addr), 64'h1010);
      sba_addr = 64'hFFF8 - 64'(i * 8);
      if (i < 3) begin
        @(negedge clk);
        lat++;
      end
    end
    gnt_en = 1'b1;
    wait_resp(1'b0, lat);
    check("stall_lat", 64'(lat), 64'd6);
    check("stall_rdata", sba_rdata, 64'h00000000_C0DE1010);
    check("stall_err", {63'd0, sba_err}, 64'd0);

    // reset while in HI_WAIT, then a stale rvalid in IDLE
    block_hi = 1'b1;
    start(1'b0, 64'h1000, 1'b0, 64'd0, 8'hFF, lat);
    repeat (3) @(negedge clk);
    check("hiwait_noresp", {63'd0, sba_rvalid}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    block_hi = 1'b0;
    check("rst_gnt", {63'd0, sba_gnt}, 64'd0);
    check("rst_memreq2", {63'd0, mem_req}, 64'd0);
    check("rst_memaddr", 64'(mem_addr), 64'd0);
    check("rst_membe", 64'(mem_be), 64'd0);
    check("rst_memwd", 64'(mem_wdata), 64'd0);
    check("rst_memwe", {63'd0, mem_we}, 64'd0);
    check("rst_rvalid2", {63'd0, sba_rvalid}, 64'd0);
    check("rst_rdata2", sba_rdata, 64'd0);
    check("rst_err2", {63'd0, sba_err}, 64'd0);
    man_rvalid = 1'b1; man_err = 1'b1;
    @(negedge clk);
    man_rvalid = 1'b0; man_err = 1'b0;
    @(negedge clk);
    check("stale_rvalid", {63'd0, sba_rvalid}, 64'd0);
    check("stale_err", {63'd0, sba_err}, 64'd0);
    check("stale_rdata", sba_rdata, 64'd0);

    // normal read after reset, upper half only
    b0 = beats;
    start(1'b0, 64'h1000, 1'b0, 64'd0, 8'hF0, lat);
    wait_resp(1'b0, lat);
    check("post_lat", 64'(lat), 64'd3);
    check("post_rdata", sba_rdata, 64'hAABBCCDD_00000000);
    check("post_err", {63'd0, sba_err}, 64'd0);
    check("post_beats", 64'(beats - b0), 64'd1);
    check("post_addr", 64'(last_addr), 64'h1004);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
